unified_mem_arbiter: RTL



---
 rtl/riscv_pkg.sv | 17 +
 rtl/unified_mem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned DEF_MEM_LAT    = 1;
  localparam int unsigned DEF_STARVE_MAX = 4;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and load/store.
// Data side wins arbitration unless fetch has waited STARVE_MAX data grants.
module unified_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned     SC_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [3:0]      LAT_INIT   = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              starve_fire;
  logic              addr_lsb_unused;

  // Memory is word addressed; byte offsets are dropped.
  assign addr_lsb_unused = ^{i_addr[1:0], d_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      we_q        <= 1'b0;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    starve_fire = i_req && (STARVE_MAX != 0) && (starve_q == STARVE_LIM);

    case (state_q)
      IDLE: begin
        if (d_req && !starve_fire) begin
          owner_d     = OWN_D;
          we_d        = d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = d_wdata;
          mem_wmask_d = d_we ? d_wmask : 4'b0000;
          state_d     = ISSUE;
          if (!i_req)
            starve_d = '0;
          else if (starve_q != STARVE_LIM)
            starve_d = starve_q + SC_W'(1);
        end else if (i_req) begin
          owner_d     = OWN_I;
          we_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = '0;
          mem_wmask_d = 4'b0000;
          starve_d    = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          if (owner_q == OWN_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!we_q)
              d_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Requests are not looked at here, so a held request is never re-granted stale.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign stall_if  = i_req & ~i_done_q;
  assign stall_mem = d_req & ~d_done_q;

endmodule
